// File: rtl/mips_btb_predictor.sv
// Branch predictor feeding the fetch stage.
// Direct-mapped BTB with one 2-bit saturating counter per entry. The current
// fetch word address is looked up every cycle to give a taken/not-taken
// prediction and a target. Resolved branches from EX train the table one
// cycle later, with no bypass. The block also counts lookups and mispredicts.
module mips_btb_predictor #(
  parameter int         BTB_ENTRIES = 16,
  parameter int         INDEX_BITS  = 4,
  parameter logic [1:0] CTR_INIT    = 2'b10,
  parameter int         PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              stall,
  input  logic [29:0]       inst_addr_PC,
  output logic              br_pred_taken,
  output logic              br_pred_not_taken,
  output logic [29:0]       branch_prediction_addr,
  input  logic              upd_valid,
  input  logic [29:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [29:0]       upd_target,
  input  logic              upd_mispredict,
  output logic [PERF_W-1:0] perf_lookups,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int TAG_W = 30 - INDEX_BITS;

  // Table storage. Each array has a next-state copy.
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
  logic [29:0]            target_q [BTB_ENTRIES];
  logic [29:0]            target_d [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [1:0]             ctr_d    [BTB_ENTRIES];

  // The active flag holds predictions off during the first cycle after reset.
  logic              active_q, active_d;
  logic [PERF_W-1:0] perf_lookups_q, perf_lookups_d;
  logic [PERF_W-1:0] perf_mispredicts_q, perf_mispredicts_d;

  // Lookup-side decode.
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;
  logic                  lk_en;
  logic                  pred_taken;

  // Update-side decode.
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  upd_hit;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  assign lk_idx  = inst_addr_PC[INDEX_BITS-1:0];
  assign lk_tag  = inst_addr_PC[29:INDEX_BITS];
  assign upd_idx = upd_pc[INDEX_BITS-1:0];
  assign upd_tag = upd_pc[29:INDEX_BITS];

  // Lookup reads only registered state, so an update in the same cycle is not visible yet.
  always_comb begin
    lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_en      = active_q && !stall;
    pred_taken = lk_en && lk_hit && ctr_q[lk_idx][1];
    upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  end

  assign br_pred_taken          = pred_taken;
  assign br_pred_not_taken      = lk_en && !pred_taken;
  assign branch_prediction_addr = pred_taken ? target_q[lk_idx] : 30'd0;
  assign perf_lookups           = perf_lookups_q;
  assign perf_mispredicts       = perf_mispredicts_q;

  // Table training. A taken miss allocates or replaces the entry; a not-taken miss leaves it alone.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_d[upd_idx]    = sat_inc(ctr_q[upd_idx]);
          target_d[upd_idx] = upd_target;
        end else begin
          ctr_d[upd_idx]    = sat_dec(ctr_q[upd_idx]);
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = CTR_INIT;
      end
    end
  end

  // Active flag and performance counters. The counters wrap naturally.
  always_comb begin
    active_d           = 1'b1;
    perf_lookups_d     = perf_lookups_q + PERF_W'(lk_en);
    perf_mispredicts_d = perf_mispredicts_q + PERF_W'(upd_valid && upd_mispredict);
  end

  // State registers. Reset invalidates every entry and discards any update in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q            <= '0;
      active_q           <= 1'b0;
      perf_lookups_q     <= '0;
      perf_mispredicts_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else begin
      valid_q            <= valid_d;
      active_q           <= active_d;
      perf_lookups_q     <= perf_lookups_d;
      perf_mispredicts_q <= perf_mispredicts_d;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mips_btb_predictor.sv
// Directed testbench for mips_btb_predictor. Expected values are worked out by
// hand. A small model tracks only the count of qualifying lookups.
module tb_mips_btb_predictor;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        stall;
  logic [29:0] inst_addr_PC;
  logic        br_pred_taken;
  logic        br_pred_not_taken;
  logic [29:0] branch_prediction_addr;
  logic        upd_valid;
  logic [29:0] upd_pc;
  logic        upd_taken;
  logic [29:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] perf_lookups;
  logic [31:0] perf_mispredicts;

  int compared   = 0;
  int mismatched = 0;
  int exp_lk     = 0;
  bit active_exp = 1'b0;

  always #5 clk = ~clk;

  mips_btb_predictor dut (
    .clk                    (clk),
    .rst_b                  (rst_b),
    .stall                  (stall),
    .inst_addr_PC           (inst_addr_PC),
    .br_pred_taken          (br_pred_taken),
    .br_pred_not_taken      (br_pred_not_taken),
    .branch_prediction_addr (branch_prediction_addr),
    .upd_valid              (upd_valid),
    .upd_pc                 (upd_pc),
    .upd_taken              (upd_taken),
    .upd_target             (upd_target),
    .upd_mispredict         (upd_mispredict),
    .perf_lookups           (perf_lookups),
    .perf_mispredicts       (perf_mispredicts)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
      $display("ok   %s observed=0x%0h", tag, obs);
    else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for the next negative edge, then check all three prediction outputs.
  task automatic chk_pred(input string tag, input logic t, input logic nt, input logic [29:0] addr);
    @(negedge clk);
    chk({tag, "_taken"}, 32'(br_pred_taken), 32'(t));
    chk({tag, "_not_taken"}, 32'(br_pred_not_taken), 32'(nt));
    chk({tag, "_addr"}, 32'(branch_prediction_addr), 32'(addr));
  endtask

  // Advance one clock. The model counts a lookup when the DUT does.
  task automatic cyc();
    @(posedge clk);
    if (rst_b) begin
      if (active_exp && !stall) exp_lk++;
      active_exp = 1'b1;
    end
    #1;
  endtask

  initial begin
    rst_b = 1'b1; stall = 1'b0; inst_addr_PC = 30'h00100000;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    #1 rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_pred("rst", 1'b0, 1'b0, 30'h0);
    chk("rst_lookups", perf_lookups, 32'd0);
    chk("rst_mispredicts", perf_mispredicts, 32'd0);

    // Release reset. Cycle 0 is inactive; cycle 1 predicts not-taken.
    @(posedge clk);
    #1 rst_b = 1'b1;
    chk_pred("cyc0", 1'b0, 1'b0, 30'h0);
    cyc();
    chk_pred("cyc1", 1'b0, 1'b1, 30'h0);
    chk("cyc1_lookups", perf_lookups, 32'd0);
    cyc();
    @(negedge clk);
    chk("cyc2_lookups", perf_lookups, 32'd1);

    // Allocate 0x00100004. The same-cycle lookup still sees the old contents.
    cyc();
    inst_addr_PC = 30'h00100004;
    upd_valid = 1'b1; upd_pc = 30'h00100004; upd_taken = 1'b1; upd_target = 30'h00100010;
    chk_pred("same_cycle", 1'b0, 1'b1, 30'h0);
    cyc();
    upd_valid = 1'b0;
    chk_pred("alloc", 1'b1, 1'b0, 30'h00100010);

    // Two not-taken updates take the counter from 2 to 1 to 0.
    cyc();
    upd_valid = 1'b1; upd_taken = 1'b0;
    chk_pred("dec_ctr2", 1'b1, 1'b0, 30'h00100010);
    cyc();
    chk_pred("dec_ctr1", 1'b0, 1'b1, 30'h0);
    cyc();
    upd_valid = 1'b0;
    chk_pred("dec_ctr0", 1'b0, 1'b1, 30'h0);

    // Four taken updates saturate the counter at 3 and retarget the entry.
    cyc();
    upd_valid = 1'b1; upd_taken = 1'b1; upd_target = 30'h00100020;
    repeat (4) cyc();
    upd_valid = 1'b0;
    chk_pred("sat", 1'b1, 1'b0, 30'h00100020);
    cyc();
    upd_valid = 1'b1; upd_taken = 1'b0;
    cyc();
    upd_valid = 1'b0;
    chk_pred("sat_dec_to2", 1'b1, 1'b0, 30'h00100020);
    cyc();
    upd_valid = 1'b1;
    cyc();
    upd_valid = 1'b0;
    chk_pred("sat_dec_to1", 1'b0, 1'b1, 30'h0);

    // 0x00100014 aliases index 4 and replaces the entry for 0x00100004.
    cyc();
    upd_valid = 1'b1; upd_pc = 30'h00100014; upd_taken = 1'b1; upd_target = 30'h00100030;
    cyc();
    upd_valid = 1'b0;
    chk_pred("alias_old_miss", 1'b0, 1'b1, 30'h0);
    cyc();
    inst_addr_PC = 30'h00100014;
    chk_pred("alias_new_hit", 1'b1, 1'b0, 30'h00100030);

    // A not-taken update that misses allocates nothing.
    cyc();
    upd_valid = 1'b1; upd_pc = 30'h00100008; upd_taken = 1'b0;
    cyc();
    upd_valid = 1'b0; inst_addr_PC = 30'h00100008;
    chk_pred("nt_miss_noalloc", 1'b0, 1'b1, 30'h0);

    // An update to a different index does not disturb the current lookup.
    cyc();
    inst_addr_PC = 30'h00100014;
    upd_valid = 1'b1; upd_pc = 30'h00100009; upd_taken = 1'b1; upd_target = 30'h00000040;
    chk_pred("indep_lookup", 1'b1, 1'b0, 30'h00100030);
    cyc();
    upd_valid = 1'b0; inst_addr_PC = 30'h00100009;
    chk_pred("indep_alloc", 1'b1, 1'b0, 30'h00000040);
    chk("pre_stall_lookups", perf_lookups, 32'(exp_lk));

    // Stall for three cycles. Training continues: 0x00100014 drops from counter 2 to 1.
    cyc();
    stall = 1'b1; inst_addr_PC = 30'h00100014;
    upd_valid = 1'b1; upd_pc = 30'h00100014; upd_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_pred($sformatf("stall%0d", i), 1'b0, 1'b0, 30'h0);
      chk($sformatf("stall%0d_lookups", i), perf_lookups, 32'(exp_lk));
      cyc();
      upd_valid = 1'b0;
    end
    stall = 1'b0;
    chk_pred("post_stall", 1'b0, 1'b1, 30'h0);
    chk("post_stall_lookups", perf_lookups, 32'(exp_lk));

    // Five mispredict pulses. A mispredict without upd_valid does not count.
    cyc();
    upd_valid = 1'b1; upd_pc = 30'h00100100; upd_taken = 1'b0; upd_mispredict = 1'b1;
    repeat (5) cyc();
    upd_valid = 1'b0;
    cyc();
    upd_mispredict = 1'b0;
    @(negedge clk);
    chk("mispredicts", perf_mispredicts, 32'd5);
    chk("lookups_total", perf_lookups, 32'(exp_lk));

    // Reset mid-operation while an update is pending.
    upd_valid = 1'b1; upd_pc = 30'h00100009; upd_taken = 1'b1; upd_target = 30'h00000050;
    inst_addr_PC = 30'h00100009;
    rst_b = 1'b0; active_exp = 1'b0; exp_lk = 0;
    #1;
    chk("midrst_taken", 32'(br_pred_taken), 32'd0);
    chk("midrst_not_taken", 32'(br_pred_not_taken), 32'd0);
    chk("midrst_addr", 32'(branch_prediction_addr), 32'd0);
    chk("midrst_lookups", perf_lookups, 32'd0);
    chk("midrst_mispredicts", perf_mispredicts, 32'd0);
    @(posedge clk);
    #1 upd_valid = 1'b0;
    @(posedge clk);
    #1 rst_b = 1'b1;
    cyc();
    chk_pred("after_rst_invalid", 1'b0, 1'b1, 30'h0);
    cyc();
    @(negedge clk);
    chk("after_rst_lookups", perf_lookups, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
